reset_request_controller: RTL and testbench
===========================================

Name: reset_request_controller

Overview:
- Source-side counterpart to the Synchronizer reset path. It generates the `source_rst` level that a downstream reset generator carries into a target clock domain.
- It arbitrates reset requests (power-on, software, watchdog, external) and enforces a minimum assertion width.
- It handshakes with the target domain through a reset acknowledge, so `source_rst` is released only after the target has actually entered reset.
- A lockout window follows each release.

Parameters:
- MIN_ASSERT, 16, minimum number of source_clk cycles `source_rst` stays high (must be at least 1).
- ACK_TIMEOUT, 255, maximum cycles spent waiting for each acknowledge edge before proceeding.
- HOLDOFF, 8, cycles after the acknowledge falls during which new requests are ignored.
- SYNC_DEPTH, 2, number of flops used to synchronize `target_rst_ack` into source_clk (must be at least 2).

Ports:
- source_clk  input  1  block clock.
- source_rst_n  input  1  asynchronous, active-low reset.
- sw_rst_req  input  1  single-cycle software reset request.
- wdt_rst_req  input  1  single-cycle watchdog reset request.
- ext_rst_req  input  1  external reset request, level, already synchronous to source_clk.
- target_rst_ack  input  1  asynchronous level from the target domain; high while the target is held in reset.
- timeout_clr  input  1  single-cycle clear of `ack_timeout`.
- source_rst  output  1  registered reset request to the downstream reset generator; active-high.
- busy  output  1  high whenever the state is not IDLE.
- rst_cause  output  2  cause of the last reset: 0 = POR, 1 = SW, 2 = WDT, 3 = EXT.
- ack_timeout  output  1  sticky flag: a wait for an acknowledge edge expired.

Behaviour:
- Values while `source_rst_n` is low:
  - `source_rst` = 1, `busy` = 1, `rst_cause` = 0, `ack_timeout` = 0.
  - State = ASSERT, counter = 0, synchronizer flops = 0.
- Reset mid-operation: asserting `source_rst_n` in any state returns to the values above immediately. Power-on therefore always runs a full POR sequence.
- `target_rst_ack` passes through a SYNC_DEPTH-flop synchronizer; the result is `ack_s`. All decisions below use `ack_s` only.
- Counter width is $clog2(max(MIN_ASSERT, ACK_TIMEOUT, HOLDOFF) + 1). The counter is saturating and is cleared on every state entry.
- IDLE:
  - Any request is accepted; `source_rst` goes to 1 on the next edge; go to ASSERT.
  - `rst_cause` is captured on the same edge.
  - Priority for simultaneous requests: EXT > WDT > SW.
- ASSERT:
  - `source_rst` = 1.
  - After MIN_ASSERT cycles (counter reaches MIN_ASSERT−1), go to WAIT_ACK.
- WAIT_ACK:
  - `source_rst` = 1.
  - On `ack_s` = 1, go to RELEASE.
  - If the counter reaches ACK_TIMEOUT first: set `ack_timeout` and go to RELEASE anyway.
- RELEASE:
  - `source_rst` = 0 from the first cycle in this state.
  - On `ack_s` = 0, go to HOLDOFF.
  - On timeout: set `ack_timeout` and go to HOLDOFF.
- HOLDOFF:
  - `source_rst` = 0.
  - After HOLDOFF cycles, go to IDLE.
- Requests arriving in any state other than IDLE are dropped; pulse requests are not queued.
- An `ext_rst_req` that is still high on return to IDLE retriggers the sequence on the next edge.
- `ack_timeout` clears on `timeout_clr` unless it is set on the same cycle; set wins.
- `busy` is registered and equals (state != IDLE).
- Minimum request-to-IDLE latency is 1 + MIN_ASSERT + 2·(SYNC_DEPTH + 1) + HOLDOFF cycles, approximately.

Decomposition:
- Package `synchronizer_pkg` holds:
  - typedef `rst_state_e` with values IDLE, ASSERT, WAIT_ACK, RELEASE, HOLDOFF;
  - typedef `rst_cause_e` with values POR, SW, WDT, EXT;
  - localparam function computing the counter width.
- One sub-module, `bit_synchronizer`: a SYNC_DEPTH-flop level synchronizer with asynchronous active-low clear. It is used for `target_rst_ack`.

Test Plan:
- Power-on, with an ack model that echoes `source_rst` after a 3-cycle delay:
  - `source_rst` is high for at least 16 cycles after `source_rst_n` rises.
  - `source_rst` falls only after `ack_s` has risen.
  - `busy` falls HOLDOFF = 8 cycles after `ack_s` falls.
  - `rst_cause` = 0 throughout.
- Idle, then `sw_rst_req` and `wdt_rst_req` pulsed on the same cycle:
  - `source_rst` goes to 1 on the next edge.
  - `rst_cause` = 2.
  - A second `sw_rst_req` pulsed during ASSERT is dropped: only one sequence runs.
- `target_rst_ack` tied low:
  - WAIT_ACK expires after 255 cycles; `ack_timeout` = 1; `source_rst` falls.
  - Pulsing `timeout_clr` afterwards gives `ack_timeout` = 0.
- `ext_rst_req` held high continuously:
  - Back-to-back sequences occur.
  - Each shows `source_rst` high for at least 16 cycles and a gap of at least 8 + 2 cycles after `ack_s` falls.
  - `rst_cause` = 3.
- `source_rst_n` asserted during RELEASE:
  - `source_rst` = 1 and `busy` = 1 immediately (asynchronously).
  - `rst_cause` = 0 and `ack_timeout` = 0.
  - After `source_rst_n` is released, a full POR sequence runs.
- Parameter sweep (MIN_ASSERT = 1, HOLDOFF = 1, SYNC_DEPTH = 3): sequence ordering and minimum widths all hold.

Source files
------------

// File: rtl/synchronizer_pkg.sv
// Shared types for the source-side reset request controller: FSM states,
// reset cause encoding and the sizing helper for the shared cycle counter.
package synchronizer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ASSERT,
        WAIT_ACK,
        RELEASE,
        HOLDOFF
    } rst_state_e;

    typedef enum logic [1:0] {
        POR,
        SW,
        WDT,
        EXT
    } rst_cause_e;

    // One counter serves every timed state, so it must hold the largest limit.
    function automatic int cnt_width(input int min_assert, input int ack_timeout,
                                     input int holdoff);
        int m;
        m = min_assert;
        if (ack_timeout > m) m = ack_timeout;
        if (holdoff > m) m = holdoff;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop level synchronizer with asynchronous active-low clear; carries a
// slow level from a foreign clock domain into the local one.
module bit_synchronizer #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] sync_q;
    logic [DEPTH-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[DEPTH-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[DEPTH-1];

endmodule

// File: rtl/reset_request_controller.sv
// Arbitrates reset requests and drives source_rst toward the target domain,
// releasing it only once the target acknowledges it has entered reset.
module reset_request_controller #(
    parameter int MIN_ASSERT  = 16,
    parameter int ACK_TIMEOUT = 255,
    parameter int HOLDOFF     = 8,
    parameter int SYNC_DEPTH  = 2
) (
    input  logic       source_clk,
    input  logic       source_rst_n,
    input  logic       sw_rst_req,
    input  logic       wdt_rst_req,
    input  logic       ext_rst_req,
    input  logic       target_rst_ack,
    input  logic       timeout_clr,
    output logic       source_rst,
    output logic       busy,
    output logic [1:0] rst_cause,
    output logic       ack_timeout
);

    import synchronizer_pkg::*;

    localparam int CW = cnt_width(MIN_ASSERT, ACK_TIMEOUT, HOLDOFF);
    localparam logic [CW-1:0] ASSERT_LAST  = CW'(MIN_ASSERT - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(ACK_TIMEOUT - 1);
    localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLDOFF - 1);
    localparam logic [CW-1:0] CNT_MAX      = '1;

    rst_state_e    state_q, state_d;
    rst_cause_e    cause_q, cause_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          src_rst_q, src_rst_d;
    logic          busy_q, busy_d;
    logic          timeout_q, timeout_d;
    logic          timeout_set;
    logic          ack_s;

    bit_synchronizer #(
        .DEPTH(SYNC_DEPTH)
    ) u_ack_sync (
        .clk  (source_clk),
        .rst_n(source_rst_n),
        .d    (target_rst_ack),
        .q    (ack_s)
    );

    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        timeout_set = 1'b0;

        case (state_q)
            IDLE: begin
                if (ext_rst_req) begin
                    state_d = ASSERT;
                    cause_d = EXT;
                end else if (wdt_rst_req) begin
                    state_d = ASSERT;
                    cause_d = WDT;
                end else if (sw_rst_req) begin
                    state_d = ASSERT;
                    cause_d = SW;
                end
            end
            ASSERT: begin
                if (cnt_q >= ASSERT_LAST) state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                // A real acknowledge on the expiring cycle is not a timeout.
                if (ack_s) begin
                    state_d = RELEASE;
                end else if (cnt_q >= TIMEOUT_LAST) begin
                    state_d     = RELEASE;
                    timeout_set = 1'b1;
                end
            end
            RELEASE: begin
                if (!ack_s) begin
                    state_d = synchronizer_pkg::HOLDOFF;
                end else if (cnt_q >= TIMEOUT_LAST) begin
                    state_d     = synchronizer_pkg::HOLDOFF;
                    timeout_set = 1'b1;
                end
            end
            synchronizer_pkg::HOLDOFF: begin
                if (cnt_q >= HOLD_LAST) state_d = IDLE;
            end
            default: state_d = ASSERT;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        // Outputs are registered from the next state so they line up with it.
        src_rst_d = (state_d == ASSERT) || (state_d == WAIT_ACK);
        busy_d    = (state_d != IDLE);

        if (timeout_set) begin
            timeout_d = 1'b1;
        end else if (timeout_clr) begin
            timeout_d = 1'b0;
        end else begin
            timeout_d = timeout_q;
        end
    end

    always_ff @(posedge source_clk or negedge source_rst_n) begin
        if (!source_rst_n) begin
            state_q   <= ASSERT;
            cause_q   <= POR;
            cnt_q     <= '0;
            src_rst_q <= 1'b1;
            busy_q    <= 1'b1;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            cnt_q     <= cnt_d;
            src_rst_q <= src_rst_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign source_rst  = src_rst_q;
    assign busy        = busy_q;
    assign rst_cause   = cause_q;
    assign ack_timeout = timeout_q;

endmodule

// File: tb/tb_reset_request_controller.sv
// Scoreboard bench: stimulus queues the expected profile of each reset
// sequence; a monitor measures every completed sequence and compares.
module tb_reset_request_controller;
    import synchronizer_pkg::*;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       sw = 1'b0, wdt = 1'b0, ext = 1'b0, tclr = 1'b0, ack_en = 1'b1;
    logic [2:0] ack_sh = '0, ack_sh2 = '0;
    logic       ack1, ack2;
    logic       srst, busy, ato, srst2, busy2, ato2;
    logic [1:0] cause, cause2;

    assign ack1 = ack_en & ack_sh[2];
    assign ack2 = ack_sh2[2];

    reset_request_controller dut (
        .source_clk(clk), .source_rst_n(rst_n), .sw_rst_req(sw), .wdt_rst_req(wdt),
        .ext_rst_req(ext), .target_rst_ack(ack1), .timeout_clr(tclr),
        .source_rst(srst), .busy(busy), .rst_cause(cause), .ack_timeout(ato));

    reset_request_controller #(.MIN_ASSERT(1), .HOLDOFF(1), .SYNC_DEPTH(3)) dut2 (
        .source_clk(clk), .source_rst_n(rst_n), .sw_rst_req(sw), .wdt_rst_req(wdt),
        .ext_rst_req(ext), .target_rst_ack(ack2), .timeout_clr(tclr),
        .source_rst(srst2), .busy(busy2), .rst_cause(cause2), .ack_timeout(ato2));

    always #5 clk = ~clk;

    // Target-domain model: acknowledge echoes source_rst three cycles later.
    always @(posedge clk) begin
        ack_sh  <= {ack_sh[1:0], srst};
        ack_sh2 <= {ack_sh2[1:0], srst2};
    end

    int passed = 0, total = 0;

    function automatic void chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endfunction

    function automatic void chk_rng(input string name, input int act, input int lo, input int hi);
        total++;
        if (act >= lo && act <= hi) passed++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    endfunction

    // hi: source_rst-high samples; saw_ack: ack_s was high when source_rst
    // fell; gap: release cycle seeing ack low plus the holdoff cycles.
    typedef struct {
        int cause; int hi_lo; int hi_hi; int saw_ack; int gap; int to;
    } exp_t;
    exp_t sb[$];

    function automatic void push(input int c, input int lo, input int hi,
                                 input int sa, input int g, input int t);
        exp_t e;
        e.cause = c; e.hi_lo = lo; e.hi_hi = hi; e.saw_ack = sa; e.gap = g; e.to = t;
        sb.push_back(e);
    endfunction

    int done1 = 0, done2 = 0;

    initial begin : mon1
        int hi, gap, fell, sawack;
        logic pb, ps, pa;
        exp_t e;
        hi = 0; gap = 0; fell = 0; sawack = 0; pb = 1'b1; ps = 1'b1; pa = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hi = 0; gap = 0; fell = 0; sawack = 0; pb = 1'b1; ps = 1'b1; pa = 1'b0;
            end else begin
                if (srst) hi++;
                if (ps && !srst) sawack = int'(pa);
                if (!srst && busy && !dut.ack_s && (fell != 0 || pa)) begin
                    fell = 1; gap++;
                end
                if (pb && !busy) begin
                    if (sb.size() == 0) begin
                        total++;
                        $display("FAIL unexpected_sequence: got sequence %0d, expected none", done1);
                    end else begin
                        e = sb.pop_front();
                        chk("seq_cause", int'(cause), e.cause);
                        chk_rng("seq_rst_width", hi, e.hi_lo, e.hi_hi);
                        chk("seq_ack_before_release", sawack, e.saw_ack);
                        chk("seq_holdoff_gap", gap, e.gap);
                        chk("seq_ack_timeout", int'(ato), e.to);
                    end
                    done1++;
                    hi = 0; gap = 0; fell = 0;
                end
                pb = busy; ps = srst; pa = dut.ack_s;
            end
        end
    end

    initial begin : mon2
        int hi, gap, fell, sawack;
        logic pb, ps, pa;
        hi = 0; gap = 0; fell = 0; sawack = 0; pb = 1'b1; ps = 1'b1; pa = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hi = 0; gap = 0; fell = 0; sawack = 0; pb = 1'b1; ps = 1'b1; pa = 1'b0;
            end else begin
                if (srst2) hi++;
                if (ps && !srst2) sawack = int'(pa);
                if (!srst2 && busy2 && !dut2.ack_s && (fell != 0 || pa)) begin
                    fell = 1; gap++;
                end
                if (pb && !busy2) begin
                    chk_rng("sweep_rst_width", hi, 1, 40);
                    chk("sweep_ack_before_release", sawack, 1);
                    chk("sweep_holdoff_gap", gap, 2);
                    done2++;
                    hi = 0; gap = 0; fell = 0;
                end
                pb = busy2; ps = srst2; pa = dut2.ack_s;
            end
        end
    end

    task automatic wait_done(input int n, input int budget, input string name);
        int b;
        b = budget;
        while (done1 < n && b > 0) begin
            @(negedge clk);
            b--;
        end
        if (done1 < n) chk(name, done1, n);
    endtask

    initial begin : stim
        int b;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_source_rst", int'(srst), 1);
        chk("reset_busy", int'(busy), 1);
        chk("reset_cause", int'(cause), 0);
        chk("reset_ack_timeout", int'(ato), 0);

        // Power-on sequence with echoing acknowledge.
        push(0, 16, 20, 1, 9, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        wait_done(1, 200, "por_done");
        chk("por_idle_busy", int'(busy), 0);

        // SW and WDT together: WDT wins; a later SW during ASSERT is dropped.
        @(negedge clk); sw = 1'b1; wdt = 1'b1;
        push(2, 16, 20, 1, 9, 0);
        @(negedge clk); sw = 1'b0; wdt = 1'b0;
        chk("req_next_edge_source_rst", int'(srst), 1);
        chk("req_cause_wdt", int'(cause), 2);
        repeat (5) @(negedge clk);
        sw = 1'b1;
        @(negedge clk); sw = 1'b0;
        wait_done(2, 200, "wdt_done");
        repeat (30) @(negedge clk);
        chk("dropped_req_stays_idle", int'(busy), 0);

        // Acknowledge tied low: WAIT_ACK expires, sticky flag, then clear.
        ack_en = 1'b0;
        @(negedge clk); sw = 1'b1;
        push(1, 271, 272, 0, 0, 1);
        @(negedge clk); sw = 1'b0;
        wait_done(3, 600, "timeout_done");
        chk("timeout_flag_set", int'(ato), 1);
        @(negedge clk); tclr = 1'b1;
        @(negedge clk); tclr = 1'b0;
        chk("timeout_flag_cleared", int'(ato), 0);

        // EXT held: back-to-back sequences; drop it after the third completes.
        ack_en = 1'b1;
        repeat (4) push(3, 16, 20, 1, 9, 0);
        @(negedge clk); ext = 1'b1;
        wait_done(6, 400, "ext_three_done");
        @(negedge clk); ext = 1'b0;
        wait_done(7, 200, "ext_fourth_done");

        // Reset asserted in RELEASE (reached via timeout so the flag is set).
        ack_en = 1'b0;
        @(negedge clk); sw = 1'b1;
        @(negedge clk); sw = 1'b0;
        b = 400;
        while (dut.state_q != RELEASE && b > 0) begin
            @(negedge clk);
            b--;
        end
        chk("reach_release", int'(dut.state_q == RELEASE), 1);
        chk("pre_reset_ack_timeout", int'(ato), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_source_rst", int'(srst), 1);
        chk("async_reset_busy", int'(busy), 1);
        chk("async_reset_cause", int'(cause), 0);
        chk("async_reset_ack_timeout", int'(ato), 0);
        repeat (3) @(negedge clk);
        ack_en = 1'b1;
        push(0, 16, 20, 1, 9, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        wait_done(8, 200, "por_after_reset_done");

        repeat (10) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        chk_rng("sweep_sequence_count", done2, 4, 200);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL global_timeout: got no finish, expected finish before 2ms");
        $fatal(1, "bench timed out");
    end

endmodule
